rotate_fb_sched: RTL and testbench

- Frame-buffer scheduler for the rotation frame store. Decides which buffer slot the input-side writer fills and which slot the output-side scanner reads.
- The two sides run on the same clock but at unrelated frame cadences.
- Supports triple buffering (drop/repeat without tearing) and double buffering (writer stalls until the reader releases a slot).
- Sits beside the rotation RAM and drives the base addresses of its write and read address generators.

---
 rtl/rotate_fb_sched.sv | 210 +++++++++++++++++++++
 tb/tb_rotate_fb_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_fb_sched.sv
// -----------------------------------------------------------------------------
// rotate_fb_sched
//
// Frame-buffer scheduler for the rotation frame store. It tracks the role of
// each buffer slot (FREE / WRITING / READY / READING). From that it picks the
// slot the input-side writer fills and the slot the output-side scanner reads.
// It also drives the base addresses of the RAM write and read address
// generators. NBUF=3 gives triple buffering: frames are dropped or repeated,
// but never torn. NBUF=2 gives double buffering: the writer idles for a frame
// when the reader still holds the only other slot.
//
// Ports
//   clk         video clock, rising edge
//   reset_n     synchronous active-low reset
//   wr_vblank   input-side vblank (level); its rising edge completes a frame
//   rd_start    one-cycle pulse: the scanner begins a new frame
//   clr_cnt     synchronous clear of drop_cnt / rep_cnt
//   wr_allow    writer may store pixels this frame (gates RAM write enable)
//   wr_buf      slot index being written
//   wr_base     wr_buf*BUFSIZE
//   rd_buf      slot index being read
//   rd_base     rd_buf*BUFSIZE
//   rd_fresh    one-cycle pulse: rd_start was served with a new frame
//   drop_cnt    completed frames never displayed (saturating)
//   rep_cnt     rd_start events served with a repeated frame (saturating)
//   slot_state  per-slot state, slot i at bits [2i+1:2i]
// -----------------------------------------------------------------------------
module rotate_fb_sched #(
  parameter int NBUF    = 3,
  parameter int BUFSIZE = 76800,
  parameter int AW      = 18,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_vblank,
  input  logic              rd_start,
  input  logic              clr_cnt,
  output logic              wr_allow,
  output logic [1:0]        wr_buf,
  output logic [AW-1:0]     wr_base,
  output logic [1:0]        rd_buf,
  output logic [AW-1:0]     rd_base,
  output logic              rd_fresh,
  output logic [CW-1:0]     drop_cnt,
  output logic [CW-1:0]     rep_cnt,
  output logic [2*NBUF-1:0] slot_state
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } slot_e;

  slot_e         r_slot [NBUF];
  logic          r_vb_prev;
  logic          r_wr_allow;
  logic [1:0]    r_wr_buf;
  logic [AW-1:0] r_wr_base;
  logic [1:0]    r_rd_buf;
  logic [AW-1:0] r_rd_base;
  logic          r_rd_fresh;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_rep_cnt;

  slot_e         w_slot_nxt [NBUF];
  logic          w_wr_evt;
  logic          w_have_wr;
  logic          w_found_free;
  logic          w_found_ready;
  logic          w_drop;
  logic          w_rep;
  logic          w_fresh;
  logic          w_allow_nxt;
  logic [1:0]    w_wr_buf_nxt;
  logic [1:0]    w_rd_buf_nxt;
  logic [AW-1:0] w_wr_base_nxt;
  logic [AW-1:0] w_rd_base_nxt;

  // A frame completes on the rising edge of the input-side vblank.
  assign w_wr_evt = wr_vblank & ~r_vb_prev;

  // Next-state resolution. The write event is applied first. The read event
  // then works on the post-write slot states, so a frame completed in the
  // same cycle is shown at once. The writer's acquisition has already been
  // made, so it cannot grab the slot the reader frees in that cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_slot_nxt    = r_slot;
    w_wr_buf_nxt  = r_wr_buf;
    w_rd_buf_nxt  = r_rd_buf;
    w_allow_nxt   = r_wr_allow;
    w_have_wr     = 1'b0;
    w_found_free  = 1'b0;
    w_found_ready = 1'b0;
    w_drop        = 1'b0;
    w_rep         = 1'b0;
    w_fresh       = 1'b0;

    if (w_wr_evt) begin
      for (int i = 0; i < NBUF; i++) begin
        if (r_slot[i] == WRITING) w_have_wr = 1'b1;
      end
      // Only a genuinely written frame can push out an undisplayed one.
      // An idle writer completed nothing, so the READY frame survives.
      if (w_have_wr) begin
        for (int i = 0; i < NBUF; i++) begin
          if (r_slot[i] == READY) begin
            w_slot_nxt[i] = FREE;
            w_drop        = 1'b1;
          end else if (r_slot[i] == WRITING) begin
            w_slot_nxt[i] = READY;
          end
        end
      end
      // Acquisition happens only here, at a frame boundary, so a writer that
      // was idle never starts halfway through a frame.
      for (int i = 0; i < NBUF; i++) begin
        if (!w_found_free && w_slot_nxt[i] == FREE) begin
          w_found_free  = 1'b1;
          w_slot_nxt[i] = WRITING;
          w_wr_buf_nxt  = 2'(i);
        end
      end
      w_allow_nxt = w_found_free;
    end

    if (rd_start) begin
      for (int i = 0; i < NBUF; i++) begin
        if (w_slot_nxt[i] == READY) begin
          w_found_ready = 1'b1;
          w_rd_buf_nxt  = 2'(i);
        end
      end
      if (w_found_ready) begin
        for (int i = 0; i < NBUF; i++) begin
          if (w_slot_nxt[i] == READING)    w_slot_nxt[i] = FREE;
          else if (w_slot_nxt[i] == READY) w_slot_nxt[i] = READING;
        end
        w_fresh = 1'b1;
      end else begin
        w_rep = 1'b1;
      end
    end
  end

  // Bases are derived from the next index and registered alongside it, so
  // index and base always change on the same edge.
  assign w_wr_base_nxt = AW'(BUFSIZE) * AW'(w_wr_buf_nxt);
  assign w_rd_base_nxt = AW'(BUFSIZE) * AW'(w_rd_buf_nxt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the slot table is control state, not data storage, so it is
      // reset entry by entry to a consistent writer/reader assignment.
      for (int i = 0; i < NBUF; i++) begin
        if (i == 0)      r_slot[i] <= WRITING;
        else if (i == 1) r_slot[i] <= READING;
        else             r_slot[i] <= FREE;
      end
      // Treat vblank as already high, so a level present at release is not an edge.
      r_vb_prev  <= 1'b1;
      r_wr_allow <= 1'b1;
      r_wr_buf   <= 2'd0;
      r_wr_base  <= '0;
      r_rd_buf   <= 2'd1;
      r_rd_base  <= AW'(BUFSIZE);
      r_rd_fresh <= 1'b0;
      r_drop_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_vb_prev  <= wr_vblank;
      r_wr_allow <= w_allow_nxt;
      r_wr_buf   <= w_wr_buf_nxt;
      r_wr_base  <= w_wr_base_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_rd_base  <= w_rd_base_nxt;
      r_rd_fresh <= w_fresh;

      if (clr_cnt)                           r_drop_cnt <= '0;
      else if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CW'(1);

      if (clr_cnt)                         r_rep_cnt <= '0;
      else if (w_rep && (r_rep_cnt != '1)) r_rep_cnt <= r_rep_cnt + CW'(1);
    end
  end

  always_comb begin
    slot_state = '0;
    for (int i = 0; i < NBUF; i++) begin
      slot_state[2*i +: 2] = r_slot[i];
    end
  end

  assign wr_allow = r_wr_allow;
  assign wr_buf   = r_wr_buf;
  assign wr_base  = r_wr_base;
  assign rd_buf   = r_rd_buf;
  assign rd_base  = r_rd_base;
  assign rd_fresh = r_rd_fresh;
  assign drop_cnt = r_drop_cnt;
  assign rep_cnt  = r_rep_cnt;

endmodule

// File: tb/tb_rotate_fb_sched.sv
// -----------------------------------------------------------------------------
// tb_rotate_fb_sched
//
// Self-checking bench for rotate_fb_sched. Two instances are built, one
// triple-buffered (NBUF=3, CW=8) and one double-buffered (NBUF=2, CW=2). They
// share the stimulus, and the one not under test is held in reset. A
// behavioural model tracks which slot index holds each role (writer, ready
// frame, reader). It is compared with every output after every clock.
// -----------------------------------------------------------------------------
module tb_rotate_fb_sched;

  localparam int BUFSIZE = 76800;

  logic clk = 1'b0;
  logic rn3, rn2, vb, rs, cc;

  logic        w3_wr_allow, w3_rd_fresh;
  logic [1:0]  w3_wr_buf, w3_rd_buf;
  logic [17:0] w3_wr_base, w3_rd_base;
  logic [7:0]  w3_drop, w3_rep;
  logic [5:0]  w3_slot;

  logic        w2_wr_allow, w2_rd_fresh;
  logic [1:0]  w2_wr_buf, w2_rd_buf;
  logic [17:0] w2_wr_base, w2_rd_base;
  logic [1:0]  w2_drop, w2_rep;
  logic [3:0]  w2_slot;

  always #5 clk = ~clk;

  rotate_fb_sched #(.NBUF(3), .BUFSIZE(BUFSIZE), .AW(18), .CW(8)) dut3 (
    .clk(clk), .reset_n(rn3), .wr_vblank(vb), .rd_start(rs), .clr_cnt(cc),
    .wr_allow(w3_wr_allow), .wr_buf(w3_wr_buf), .wr_base(w3_wr_base),
    .rd_buf(w3_rd_buf), .rd_base(w3_rd_base), .rd_fresh(w3_rd_fresh),
    .drop_cnt(w3_drop), .rep_cnt(w3_rep), .slot_state(w3_slot)
  );

  rotate_fb_sched #(.NBUF(2), .BUFSIZE(BUFSIZE), .AW(18), .CW(2)) dut2 (
    .clk(clk), .reset_n(rn2), .wr_vblank(vb), .rd_start(rs), .clr_cnt(cc),
    .wr_allow(w2_wr_allow), .wr_buf(w2_wr_buf), .wr_base(w2_wr_base),
    .rd_buf(w2_rd_buf), .rd_base(w2_rd_base), .rd_fresh(w2_rd_fresh),
    .drop_cnt(w2_drop), .rep_cnt(w2_rep), .slot_state(w2_slot)
  );

  // Outputs of the instance under test, widened to 32 bits.
  int sel = 0;
  logic [31:0] ob_allow, ob_wr_buf, ob_wr_base, ob_rd_buf, ob_rd_base;
  logic [31:0] ob_fresh, ob_drop, ob_rep, ob_slot;

  always_comb begin
    if (sel == 0) begin
      ob_allow   = 32'(w3_wr_allow);
      ob_wr_buf  = 32'(w3_wr_buf);
      ob_wr_base = 32'(w3_wr_base);
      ob_rd_buf  = 32'(w3_rd_buf);
      ob_rd_base = 32'(w3_rd_base);
      ob_fresh   = 32'(w3_rd_fresh);
      ob_drop    = 32'(w3_drop);
      ob_rep     = 32'(w3_rep);
      ob_slot    = 32'(w3_slot);
    end else begin
      ob_allow   = 32'(w2_wr_allow);
      ob_wr_buf  = 32'(w2_wr_buf);
      ob_wr_base = 32'(w2_wr_base);
      ob_rd_buf  = 32'(w2_rd_buf);
      ob_rd_base = 32'(w2_rd_base);
      ob_fresh   = 32'(w2_rd_fresh);
      ob_drop    = 32'(w2_drop);
      ob_rep     = 32'(w2_rep);
      ob_slot    = 32'(w2_slot);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Roles are kept as slot indices (-1 = nobody holds that role).
  int m_nbuf, m_max;
  int m_wr, m_ready, m_rd, m_wr_buf, m_drop, m_rep;
  bit m_allow, m_fresh, m_prev;

  function automatic int lowest_free();
    for (int i = 0; i < m_nbuf; i++)
      if (i != m_wr && i != m_ready && i != m_rd) return i;
    return -1;
  endfunction

  function automatic int exp_slot_state();
    int s = 0;
    for (int i = 0; i < m_nbuf; i++) begin
      if (i == m_wr)         s += 1 << (2 * i);
      else if (i == m_ready) s += 2 << (2 * i);
      else if (i == m_rd)    s += 3 << (2 * i);
    end
    return s;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_wr_buf = 0; m_ready = -1; m_rd = 1;
    m_allow = 1'b1; m_fresh = 1'b0; m_drop = 0; m_rep = 0; m_prev = 1'b1;
  endtask

  task automatic model_step(input logic v, input logic r, input logic c);
    bit w, drop_inc, rep_inc;
    int f;
    w = v && !m_prev;
    m_prev = v;
    drop_inc = 1'b0;
    rep_inc  = 1'b0;
    m_fresh  = 1'b0;
    if (w) begin
      if (m_wr >= 0) begin
        if (m_ready >= 0) drop_inc = 1'b1;
        m_ready = m_wr;
        m_wr = -1;
      end
      f = lowest_free();
      if (f >= 0) begin
        m_wr = f; m_wr_buf = f; m_allow = 1'b1;
      end else begin
        m_allow = 1'b0;
      end
    end
    if (r) begin
      if (m_ready >= 0) begin
        m_rd = m_ready; m_ready = -1; m_fresh = 1'b1;
      end else begin
        rep_inc = 1'b1;
      end
    end
    if (c) begin
      m_drop = 0; m_rep = 0;
    end else begin
      if (drop_inc && m_drop < m_max) m_drop++;
      if (rep_inc && m_rep < m_max)   m_rep++;
    end
  endtask

  task automatic check_all();
    check("wr_buf",     ob_wr_buf,  m_wr_buf);
    check("wr_base",    ob_wr_base, m_wr_buf * BUFSIZE);
    check("rd_buf",     ob_rd_buf,  m_rd);
    check("rd_base",    ob_rd_base, m_rd * BUFSIZE);
    check("wr_allow",   ob_allow,   32'(m_allow));
    check("rd_fresh",   ob_fresh,   32'(m_fresh));
    check("drop_cnt",   ob_drop,    m_drop);
    check("rep_cnt",    ob_rep,     m_rep);
    check("slot_state", ob_slot,    exp_slot_state());
  endtask

  // One clock: drive at negedge, model at posedge, compare just after.
  task automatic step(input logic v, input logic r, input logic c);
    @(negedge clk);
    vb = v; rs = r; cc = c;
    @(posedge clk);
    model_step(v, r, c);
    #1;
    check_all();
  endtask

  // Reset the selected instance with vblank held high through release.
  task automatic do_reset(input int k);
    @(negedge clk);
    rn3 = 1'b0; rn2 = 1'b0; vb = 1'b1; rs = 1'b0; cc = 1'b0;
    sel = k;
    m_nbuf = (k == 0) ? 3 : 2;
    m_max  = (k == 0) ? 255 : 3;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    if (k == 0) rn3 = 1'b1;
    else        rn2 = 1'b1;
  endtask

  task automatic random_run(input int n);
    logic v;
    v = vb;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) v = ~v;
      step(v, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 29) == 0));
    end
  endtask

  initial begin
    rn3 = 1'b0; rn2 = 1'b0; vb = 1'b1; rs = 1'b0; cc = 1'b0;

    // ---------- triple buffering ----------
    do_reset(0);
    repeat (3) step(1, 0, 0);           // vblank stays high: no event
    check("rst_rd_base", ob_rd_base, 76800);
    check("rst_no_evt_wr_buf", ob_wr_buf, 0);
    check("rst_no_evt_allow", ob_allow, 1);

    step(0, 0, 0);
    step(1, 0, 0);                      // W
    check("w1_slot0_ready", 32'(ob_slot[1:0]), 2);
    check("w1_wr_buf", ob_wr_buf, 2);
    repeat (9) step(0, 0, 0);
    step(0, 1, 0);                      // R
    check("r1_rd_buf", ob_rd_buf, 0);
    check("r1_fresh", ob_fresh, 1);
    check("r1_slot1_free", 32'(ob_slot[3:2]), 0);
    step(0, 0, 0);
    check("r1_fresh_pulse", ob_fresh, 0);

    repeat (3) begin                    // three W, then one R
      step(1, 0, 0);
      step(0, 0, 0);
    end
    step(0, 1, 0);
    check("w3_drop", ob_drop, 2);
    check("w3_rd_buf", ob_rd_buf, 2);
    check("w3_wr_buf", ob_wr_buf, 1);
    step(0, 0, 0);

    repeat (4) begin                    // four R with no W
      step(0, 1, 0);
      check("rep_no_fresh", ob_fresh, 0);
    end
    check("rep4_cnt", ob_rep, 4);
    check("rep4_rd_buf", ob_rd_buf, 2);

    step(1, 1, 0);                      // W and R together
    check("wr_same_rd_buf", ob_rd_buf, 1);
    check("wr_same_fresh", ob_fresh, 1);
    check("wr_same_rep", ob_rep, 4);
    step(0, 0, 0);

    random_run(300);
    do_reset(0);                        // reset from a mid-run state
    step(1, 0, 0);
    random_run(150);

    // ---------- double buffering, CW=2 ----------
    do_reset(1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);                      // W before any R
    check("db_idle_allow", ob_allow, 0);
    step(0, 0, 0);
    step(0, 1, 0);                      // R releases slot 1
    check("db_r_rd_buf", ob_rd_buf, 0);
    step(1, 0, 0);                      // next W acquires it
    check("db_w_allow", ob_allow, 1);
    check("db_w_wr_buf", ob_wr_buf, 1);
    step(0, 0, 0);
    repeat (6) step(0, 1, 0);           // six repeats
    check("db_rep_sat", ob_rep, 3);
    step(0, 1, 1);                      // clear wins over increment
    check("db_clr_rep", ob_rep, 0);
    step(0, 0, 0);
    random_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
